// File: rtl/snake_ctrl.sv
// Snake game core: tick-driven movement on a 160x120 wrapping grid, target hit pulse, per-pixel colour; SNAKE_CTRL_GROW_EN enables growth.
// Latency: COLOUR_OUT and TARGET_REACHED are registered (1 CLK); no backpressure, inputs are sampled every cycle.
module snake_ctrl #(
  parameter int MOVE_DIV = 5000000,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  MSM_STATE,
  input  logic [1:0]  NAV_STATE,
  input  logic [7:0]  TARGET_ADDR_X,
  input  logic [6:0]  TARGET_ADDR_Y,
  input  logic [9:0]  PIXEL_ADDR_X,
  input  logic [8:0]  PIXEL_ADDR_Y,
  output logic        TARGET_REACHED,
  output logic [11:0] COLOUR_OUT
);

  typedef enum logic [1:0] {
    MSM_IDLE = 2'd0,
    MSM_PLAY = 2'd1,
    MSM_WIN  = 2'd2,
    MSM_LOSE = 2'd3
  } msm_e;

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  function automatic logic [7:0] start_x(input int idx);
    return 8'(80 - idx);
  endfunction

  msm_e msm;
  assign msm = msm_e'(MSM_STATE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             move_tick, move_en;
  logic [7:0]       seg_x_q [MAX_LEN];
  logic [7:0]       seg_x_d [MAX_LEN];
  logic [6:0]       seg_y_q [MAX_LEN];
  logic [6:0]       seg_y_d [MAX_LEN];
  logic [7:0]       head_nx_x;
  logic [6:0]       head_nx_y;
  logic             tr_q, tr_d;
  logic [11:0]      colour_q, colour_d;
  logic [MAX_LEN-1:0] seg_drawn;

  always_comb begin
    move_tick = (cnt_q == CNT_W'(MOVE_DIV - 1));
    cnt_d     = move_tick ? '0 : cnt_q + CNT_W'(1);
    move_en   = move_tick && (msm == MSM_PLAY);
  end

  // Edge wrap: the grid is a torus in both axes.
  always_comb begin
    head_nx_x = seg_x_q[0];
    head_nx_y = seg_y_q[0];
    case (NAV_STATE)
      2'd0:    head_nx_y = (seg_y_q[0] == 7'd0)   ? 7'd119 : seg_y_q[0] - 7'd1;
      2'd1:    head_nx_x = (seg_x_q[0] == 8'd159) ? 8'd0   : seg_x_q[0] + 8'd1;
      2'd2:    head_nx_y = (seg_y_q[0] == 7'd119) ? 7'd0   : seg_y_q[0] + 7'd1;
      default: head_nx_x = (seg_x_q[0] == 8'd0)   ? 8'd159 : seg_x_q[0] - 8'd1;
    endcase
  end

  always_comb begin
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    if (msm == MSM_IDLE) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = start_x(i);
        seg_y_d[i] = 7'd60;
      end
    end else if (move_en) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
      seg_x_d[0] = head_nx_x;
      seg_y_d[0] = head_nx_y;
    end
  end

  always_comb begin
    tr_d = move_en && (TARGET_ADDR_X < 8'd160) && (TARGET_ADDR_Y < 7'd120) &&
           (head_nx_x == TARGET_ADDR_X) && (head_nx_y == TARGET_ADDR_Y);
  end

`ifdef SNAKE_CTRL_GROW_EN
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic [LEN_W-1:0] len_q, len_d;

  always_comb begin
    len_d = len_q;
    if (msm == MSM_IDLE) begin
      len_d = LEN_W'(INIT_LEN);
    end else if (tr_q && (len_q < LEN_W'(MAX_LEN))) begin
      len_d = len_q + LEN_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      len_q <= LEN_W'(INIT_LEN);
    end else begin
      len_q <= len_d;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_drawn[i] = (i < int'(len_q));
    end
  end
`else
  assign seg_drawn = '1;
`endif

  // Head beats body beats target beats background; off-screen pixels are black.
  always_comb begin
    logic [7:0] cell_x;
    logic [6:0] cell_y;
    logic       head_hit;
    logic       body_hit;
    cell_x   = PIXEL_ADDR_X[9:2];
    cell_y   = PIXEL_ADDR_Y[8:2];
    head_hit = seg_drawn[0] && (seg_x_q[0] == cell_x) && (seg_y_q[0] == cell_y);
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (seg_drawn[i] && (seg_x_q[i] == cell_x) && (seg_y_q[i] == cell_y)) begin
        body_hit = 1'b1;
      end
    end
    if ((PIXEL_ADDR_X >= 10'd640) || (PIXEL_ADDR_Y >= 9'd480)) begin
      colour_d = 12'h000;
    end else if (head_hit) begin
      colour_d = 12'hFF0;
    end else if (body_hit) begin
      colour_d = 12'h0F0;
    end else if ((cell_x == TARGET_ADDR_X) && (cell_y == TARGET_ADDR_Y)) begin
      colour_d = 12'hF00;
    end else begin
      colour_d = 12'h00F;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q    <= '0;
      tr_q     <= 1'b0;
      colour_q <= 12'h000;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= start_x(i);
        seg_y_q[i] <= 7'd60;
      end
    end else begin
      cnt_q    <= cnt_d;
      tr_q     <= tr_d;
      colour_q <= colour_d;
      seg_x_q  <= seg_x_d;
      seg_y_q  <= seg_y_d;
    end
  end

  assign TARGET_REACHED = tr_q;
  assign COLOUR_OUT     = colour_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed bench for snake_ctrl with MOVE_DIV=4; snake position is observed through COLOUR_OUT by probing pixels.
module tb_snake_ctrl;

`ifdef SNAKE_CTRL_GROW_EN
  localparam bit GROW = 1'b1;
  localparam int LEN  = 4;
`else
  localparam bit GROW = 1'b0;
  localparam int LEN  = 16;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [1:0]  MSM_STATE;
  logic [1:0]  NAV_STATE;
  logic [7:0]  TARGET_ADDR_X;
  logic [6:0]  TARGET_ADDR_Y;
  logic [9:0]  PIXEL_ADDR_X;
  logic [8:0]  PIXEL_ADDR_Y;
  logic        TARGET_REACHED;
  logic [11:0] COLOUR_OUT;

  int total = 0;
  int bad   = 0;

  snake_ctrl #(.MOVE_DIV(4), .MAX_LEN(16), .INIT_LEN(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .MSM_STATE     (MSM_STATE),
    .NAV_STATE     (NAV_STATE),
    .TARGET_ADDR_X (TARGET_ADDR_X),
    .TARGET_ADDR_Y (TARGET_ADDR_Y),
    .PIXEL_ADDR_X  (PIXEL_ADDR_X),
    .PIXEL_ADDR_Y  (PIXEL_ADDR_Y),
    .TARGET_REACHED(TARGET_REACHED),
    .COLOUR_OUT    (COLOUR_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_c(input string tag, input logic [11:0] exp);
    total++;
    assert (COLOUR_OUT === exp) else begin
      bad++;
      $error("FAIL %s: COLOUR_OUT=%h expected %h", tag, COLOUR_OUT, exp);
    end
  endtask

  task automatic chk_t(input string tag, input logic exp);
    total++;
    assert (TARGET_REACHED === exp) else begin
      bad++;
      $error("FAIL %s: TARGET_REACHED=%b expected %b", tag, TARGET_REACHED, exp);
    end
  endtask

  task automatic probe(input string tag, input int px, input int py, input logic [11:0] exp);
    PIXEL_ADDR_X = 10'(px);
    PIXEL_ADDR_Y = 9'(py);
    tick(1);
    chk_c(tag, exp);
  endtask

  initial begin
    RESET = 1'b1; MSM_STATE = 2'd0; NAV_STATE = 2'd1;
    TARGET_ADDR_X = 8'd42; TARGET_ADDR_Y = 7'd10;
    PIXEL_ADDR_X = '0; PIXEL_ADDR_Y = '0;
    tick(2);
    chk_c("rst_colour", 12'h000);
    chk_t("rst_tr", 1'b0);

    // Static picture at the start position
    RESET = 1'b0;
    probe("px_head",   320, 240, 12'hFF0);
    probe("px_body",   316, 240, 12'h0F0);
    probe("px_target", 168,  43, 12'hF00);
    probe("px_bg",       0,   0, 12'h00F);
    probe("px_offx",   700,   0, 12'h000);
    probe("px_offy",     0, 480, 12'h000);
    probe("px_edgex",  640, 100, 12'h000);
    probe("px_corner", 639, 479, 12'h00F);
    probe("px_lastseg", 4 * (81 - LEN), 240, 12'h0F0);
    probe("px_pastlen", 4 * (80 - LEN), 240, 12'h00F);

    // Movement right towards target (83,60); moves land on edges R+4, R+8, R+12, R+16
    RESET = 1'b1; MSM_STATE = 2'd1; NAV_STATE = 2'd1;
    TARGET_ADDR_X = 8'd83; TARGET_ADDR_Y = 7'd60;
    tick(1);
    RESET = 1'b0; PIXEL_ADDR_X = 10'd324; PIXEL_ADDR_Y = 9'd240;
    tick(3);
    chk_c("pre_move", 12'h00F);
    chk_t("pre_move_tr", 1'b0);
    tick(1);
    chk_c("move_edge", 12'h00F);
    tick(1);
    chk_c("head_81", 12'hFF0);
    PIXEL_ADDR_X = 10'd320;
    tick(1);
    chk_c("seg1_80", 12'h0F0);
    PIXEL_ADDR_X = 10'd316;
    for (int k = 7; k <= 16; k++) begin
      tick(1);
      chk_t($sformatf("tr_cyc%0d", k), (k == 12));
      if (k == 13) chk_c("len_before", GROW ? 12'h00F : 12'h0F0);
      if (k == 14) chk_c("len_after", 12'h0F0);
    end

    // Freeze for 20 ticks, then return to idle
    MSM_STATE = 2'd2;
    tick(80);
    probe("frozen_head",  336, 240, 12'hFF0);
    probe("frozen_ahead", 340, 240, 12'h00F);
    chk_t("frozen_tr", 1'b0);
    MSM_STATE = 2'd0; PIXEL_ADDR_X = 10'd320;
    tick(2);
    chk_c("idle_head", 12'hFF0);
    probe("idle_len", 304, 240, GROW ? 12'h00F : 12'h0F0);

    // X wrap: 79 moves reach x=159, the 80th wraps to 0
    RESET = 1'b1; MSM_STATE = 2'd1; NAV_STATE = 2'd1;
    tick(1);
    RESET = 1'b0;
    tick(316);
    probe("x_159", 636, 240, 12'hFF0);
    PIXEL_ADDR_X = 10'd0;
    tick(4);
    chk_c("x_wrap", 12'hFF0);

    // Y wrap: 60 moves reach y=0, the 61st wraps to 119
    RESET = 1'b1; NAV_STATE = 2'd0;
    tick(1);
    RESET = 1'b0;
    tick(240);
    probe("y_0", 320, 0, 12'hFF0);
    PIXEL_ADDR_Y = 9'd476;
    tick(4);
    chk_c("y_wrap", 12'hFF0);

    // Reset coinciding with a move tick whose move would hit the target
    TARGET_ADDR_X = 8'd80; TARGET_ADDR_Y = 7'd118;
    tick(2);
    chk_t("pre_rst_tr", 1'b0);
    RESET = 1'b1; PIXEL_ADDR_Y = 9'd240;
    tick(1);
    chk_c("rst_mid_colour", 12'h000);
    chk_t("rst_mid_tr", 1'b0);
    RESET = 1'b0;
    tick(1);
    chk_c("rst_mid_head", 12'hFF0);
    chk_t("rst_mid_tr2", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
